cpri_tx_sched: RTL and testbench

Per-symbol scheduler for the two-lane CPRI TX datapath. For each accepted symbol it walks through every RBG and, per RBG, issues a load pulse, waits until both lanes are ready, then streams one framed burst (vld/sop/eop). It drives the rx_vld/rx_sop/rx_eop/rbg_load/rbg_idx and slot/symbol header inputs of both txdata_queue instances, and tracks slot/symbol numbering with wrap-around.

---
 rtl/cpri_tx_sched_if.sv | 34 +++
 rtl/cpri_tx_sched.sv | 163 ++++++++++++++++
 tb/tb_cpri_tx_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpri_tx_sched_if.sv
// Control/status bundle between the CPRI TX scheduler and its controller.
// The scheduler uses the slave modport; the controller side (or bench) uses master.
interface cpri_tx_sched_if;
    logic       i_enable;
    logic       i_symb_start;
    logic [1:0] i_lane_rdy;
    logic       i_tim_sync;
    logic [6:0] i_slot_init;
    logic [3:0] i_symb_init;
    logic       i_clr_ovr;
    logic       o_rx_vld;
    logic       o_rx_sop;
    logic       o_rx_eop;
    logic       o_rbg_load;
    logic [3:0] o_rbg_idx;
    logic [6:0] o_slot_idx;
    logic [3:0] o_symb_idx;
    logic       o_busy;
    logic       o_overrun;

    modport master (
        output i_enable, i_symb_start, i_lane_rdy, i_tim_sync, i_slot_init, i_symb_init,
               i_clr_ovr,
        input  o_rx_vld, o_rx_sop, o_rx_eop, o_rbg_load, o_rbg_idx, o_slot_idx, o_symb_idx,
               o_busy, o_overrun
    );

    modport slave (
        input  i_enable, i_symb_start, i_lane_rdy, i_tim_sync, i_slot_init, i_symb_init,
               i_clr_ovr,
        output o_rx_vld, o_rx_sop, o_rx_eop, o_rbg_load, o_rbg_idx, o_slot_idx, o_symb_idx,
               o_busy, o_overrun
    );
endinterface

// File: rtl/cpri_tx_sched.sv
// Per-symbol RBG scheduler for the two-lane CPRI TX datapath: load, wait for both
// lanes, stream one framed burst per RBG, and keep slot/symbol numbering.
module cpri_tx_sched #(
    parameter int unsigned NUM_RBG       = 16,
    parameter int unsigned RBG_LEN       = 48,
    parameter int unsigned GAP_CYC       = 4,
    parameter int unsigned SYMB_PER_SLOT = 14,
    parameter int unsigned SLOT_NUM      = 80
) (
    input logic              i_clk,
    input logic              i_reset,
    cpri_tx_sched_if.slave   sched_if
);

    localparam logic [3:0] RbgLast  = 4'(NUM_RBG - 1);
    localparam logic [7:0] BeatLast = 8'(RBG_LEN - 1);
    localparam logic [3:0] GapLast  = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);
    localparam logic [3:0] SymbLast = 4'(SYMB_PER_SLOT - 1);
    localparam logic [6:0] SlotLast = 7'(SLOT_NUM - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StWaitRdy, StStream, StGap} state_e;

    state_e     state_q, state_d;
    logic [3:0] rbg_idx_q, rbg_idx_d;
    logic [7:0] beat_q, beat_d;
    logic [3:0] gap_q, gap_d;
    logic [6:0] slot_cnt_q, slot_cnt_d, slot_idx_q, slot_idx_d;
    logic [3:0] symb_cnt_q, symb_cnt_d, symb_idx_q, symb_idx_d;
    logic       pending_q, pending_d, overrun_q, overrun_d;
    logic       vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
    logic       load_q, load_d, busy_q, busy_d;
    logic       start_acc, final_eop;

    always_comb begin
        state_d    = state_q;
        rbg_idx_d  = rbg_idx_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        slot_idx_d = slot_idx_q;
        symb_idx_d = symb_idx_q;
        final_eop  = 1'b0;
        start_acc  = sched_if.i_symb_start & sched_if.i_enable;

        unique case (state_q)
            StIdle: begin
                if (sched_if.i_enable && (sched_if.i_symb_start || pending_q)) begin
                    state_d    = StLoad;
                    rbg_idx_d  = '0;
                    slot_idx_d = slot_cnt_q;
                    symb_idx_d = symb_cnt_q;
                end
            end
            StLoad: state_d = StWaitRdy;
            StWaitRdy: begin
                if (sched_if.i_lane_rdy == 2'b11) begin
                    state_d = StStream;
                    beat_d  = '0;
                end
            end
            StStream: begin
                if (beat_q == BeatLast) begin
                    if (rbg_idx_q == RbgLast) begin
                        state_d   = StIdle;
                        final_eop = 1'b1;
                    end else if (GAP_CYC == 0) begin
                        state_d   = StLoad;
                        rbg_idx_d = rbg_idx_q + 4'd1;
                    end else begin
                        state_d = StGap;
                        gap_d   = '0;
                    end
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d   = StLoad;
                    rbg_idx_d = rbg_idx_q + 4'd1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // One start may queue behind the in-flight symbol; a second one is lost.
        pending_d = pending_q;
        overrun_d = overrun_q & ~sched_if.i_clr_ovr;
        if (state_q == StIdle && state_d == StLoad) pending_d = 1'b0;
        if (start_acc && state_q != StIdle) begin
            if (!pending_q) pending_d = 1'b1;
            else            overrun_d = 1'b1;
        end

        slot_cnt_d = slot_cnt_q;
        symb_cnt_d = symb_cnt_q;
        if (sched_if.i_tim_sync) begin
            slot_cnt_d = sched_if.i_slot_init;
            symb_cnt_d = sched_if.i_symb_init;
        end else if (final_eop) begin
            if (symb_cnt_q == SymbLast) begin
                symb_cnt_d = '0;
                slot_cnt_d = (slot_cnt_q == SlotLast) ? 7'd0 : slot_cnt_q + 7'd1;
            end else begin
                symb_cnt_d = symb_cnt_q + 4'd1;
            end
        end

        vld_d  = (state_d == StStream);
        sop_d  = (state_q == StWaitRdy) && (state_d == StStream);
        eop_d  = (state_d == StStream) && (beat_d == BeatLast);
        load_d = (state_d == StLoad);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            rbg_idx_q  <= '0;
            beat_q     <= '0;
            gap_q      <= '0;
            slot_cnt_q <= '0;
            symb_cnt_q <= '0;
            slot_idx_q <= '0;
            symb_idx_q <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            vld_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rbg_idx_q  <= rbg_idx_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            slot_cnt_q <= slot_cnt_d;
            symb_cnt_q <= symb_cnt_d;
            slot_idx_q <= slot_idx_d;
            symb_idx_q <= symb_idx_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            vld_q      <= vld_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
        end
    end

    assign sched_if.o_rx_vld   = vld_q;
    assign sched_if.o_rx_sop   = sop_q;
    assign sched_if.o_rx_eop   = eop_q;
    assign sched_if.o_rbg_load = load_q;
    assign sched_if.o_rbg_idx  = rbg_idx_q;
    assign sched_if.o_slot_idx = slot_idx_q;
    assign sched_if.o_symb_idx = symb_idx_q;
    assign sched_if.o_busy     = busy_q;
    assign sched_if.o_overrun  = overrun_q;

endmodule

// File: tb/tb_cpri_tx_sched.sv
// Scoreboard bench for cpri_tx_sched: stimulus queues expected load/beat events with
// absolute cycle numbers, a negedge monitor pops and compares each presented event.
module tb_cpri_tx_sched;
    localparam int NR = 2;
    localparam int RL = 4;
    localparam int GC = 2;

    typedef struct packed {
        int         cyc;
        logic       load;
        logic       vld;
        logic       sop;
        logic       eop;
        logic [3:0] idx;
        logic [6:0] slot;
        logic [3:0] symb;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpri_tx_sched_if bus ();

    cpri_tx_sched #(
        .NUM_RBG(NR), .RBG_LEN(RL), .GAP_CYC(GC), .SYMB_PER_SLOT(14), .SLOT_NUM(80)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .sched_if(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input bit ld, input bit sop, input bit eop,
                           input int idx, input int slot, input int symb);
        ev_t e;
        e      = '0;
        e.cyc  = c;
        e.load = ld;
        e.vld  = !ld;
        e.sop  = sop;
        e.eop  = eop;
        e.idx  = 4'(idx);
        e.slot = 7'(slot);
        e.symb = 4'(symb);
        exp_q.push_back(e);
    endtask

    // Whole symbol: per RBG a load, 2 cycles to sop (+ lane delay on RBG 0), RL beats, GC gap.
    task automatic expect_symbol(input int load_cyc, input int delay0, input int slot,
                                 input int symb);
        int l;
        int s;
        l = load_cyc;
        for (int r = 0; r < NR; r++) begin
            push_ev(l, 1'b1, 1'b0, 1'b0, r, slot, symb);
            s = l + 2 + ((r == 0) ? delay0 : 0);
            for (int b = 0; b < RL; b++) push_ev(s + b, 1'b0, b == 0, b == RL - 1, r, slot, symb);
            l = s + RL + GC;
        end
    endtask

    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        act      = '0;
        act.cyc  = cyc;
        act.load = bus.o_rbg_load;
        act.vld  = bus.o_rx_vld;
        act.sop  = bus.o_rx_sop;
        act.eop  = bus.o_rx_eop;
        act.idx  = bus.o_rbg_idx;
        act.slot = bus.o_slot_idx;
        act.symb = bus.o_symb_idx;
        if ((bus.o_rx_sop || bus.o_rx_eop) && !bus.o_rx_vld) begin
            checks++;
            errors++;
            $display("FAIL framing cyc=%0d sop/eop without vld", cyc);
        end
        if (bus.o_rbg_load || bus.o_rx_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d ld=%0b vld=%0b idx=%0d", cyc,
                         act.load, act.vld, act.idx);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL event got cyc=%0d ld=%0b vld=%0b sop=%0b eop=%0b idx=%0d slot=%0d symb=%0d want cyc=%0d ld=%0b vld=%0b sop=%0b eop=%0b idx=%0d slot=%0d symb=%0d",
                             act.cyc, act.load, act.vld, act.sop, act.eop, act.idx, act.slot,
                             act.symb, e.cyc, e.load, e.vld, e.sop, e.eop, e.idx, e.slot,
                             e.symb);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_start;
        bus.i_symb_start = 1'b1;
        tick();
        bus.i_symb_start = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_outs"}, {bus.o_rx_vld, bus.o_rx_sop, bus.o_rx_eop, bus.o_rbg_load,
                              bus.o_rbg_idx, bus.o_slot_idx, bus.o_symb_idx}, 32'd0);
        chk({name, "_busy"}, bus.o_busy, 0);
        chk({name, "_ovr"}, bus.o_overrun, 0);
    endtask

    initial begin
        bus.i_enable     = 1'b1;
        bus.i_symb_start = 1'b0;
        bus.i_lane_rdy   = 2'b11;
        bus.i_tim_sync   = 1'b0;
        bus.i_slot_init  = '0;
        bus.i_symb_init  = '0;
        bus.i_clr_ovr    = 1'b0;

        goto(3);
        chk_quiet("reset");
        rst = 1'b0;

        // 1: basic symbol, header 0/0
        goto(10);
        expect_symbol(11, 0, 0, 0);
        pulse_start();
        goto(24);
        chk("t1_busy_eop", bus.o_busy, 1);
        tick();
        chk("t1_busy_fall", bus.o_busy, 0);

        // 2: lane 1 late by 5 cycles; a drop during STREAM is ignored
        goto(30);
        expect_symbol(31, 5, 0, 1);
        pulse_start();
        bus.i_lane_rdy = 2'b01;
        goto(37);
        bus.i_lane_rdy = 2'b11;
        goto(39);
        bus.i_lane_rdy = 2'b00;
        goto(41);
        bus.i_lane_rdy = 2'b11;

        // 3: timing sync to 79/13, then wrap to 0/0
        goto(55);
        bus.i_tim_sync  = 1'b1;
        bus.i_slot_init = 7'd79;
        bus.i_symb_init = 4'd13;
        tick();
        bus.i_tim_sync  = 1'b0;
        goto(60);
        expect_symbol(61, 0, 79, 13);
        pulse_start();

        // 4: pending start and overrun; set beats same-cycle clear
        goto(80);
        expect_symbol(81, 0, 0, 0);
        pulse_start();
        goto(85);
        expect_symbol(96, 0, 0, 1);
        pulse_start();
        goto(87);
        chk("t4_ovr_before", bus.o_overrun, 0);
        goto(88);
        bus.i_symb_start = 1'b1;
        bus.i_clr_ovr    = 1'b1;
        tick();
        bus.i_symb_start = 1'b0;
        bus.i_clr_ovr    = 1'b0;
        chk("t4_ovr_set", bus.o_overrun, 1);
        goto(112);
        chk("t4_ovr_sticky", bus.o_overrun, 1);
        bus.i_clr_ovr = 1'b1;
        tick();
        bus.i_clr_ovr = 1'b0;
        chk("t4_ovr_clr", bus.o_overrun, 0);

        // 5: reset at beat 2 of RBG 0, then a clean symbol from 0/0
        goto(120);
        push_ev(121, 1'b1, 1'b0, 1'b0, 0, 0, 2);
        push_ev(123, 1'b0, 1'b1, 1'b0, 0, 0, 2);
        push_ev(124, 1'b0, 1'b0, 1'b0, 0, 0, 2);
        push_ev(125, 1'b0, 1'b0, 1'b0, 0, 0, 2);
        pulse_start();
        goto(125);
        rst = 1'b1;
        tick();
        chk_quiet("t5_reset");
        rst = 1'b0;
        goto(130);
        expect_symbol(131, 0, 0, 0);
        pulse_start();

        // 6: disabled start ignored; enable drop mid-symbol keeps the pending start
        goto(150);
        bus.i_enable = 1'b0;
        pulse_start();
        chk("t6_no_load", bus.o_rbg_load, 0);
        chk("t6_no_busy", bus.o_busy, 0);
        tick();
        chk("t6_no_ovr", bus.o_overrun, 0);
        goto(160);
        bus.i_enable = 1'b1;
        expect_symbol(161, 0, 0, 1);
        pulse_start();
        goto(163);
        pulse_start();
        goto(165);
        bus.i_enable = 1'b0;
        goto(168);
        pulse_start();
        goto(175);
        chk("t6_idle_held", bus.o_busy, 0);
        goto(180);
        chk("t6_idle_still", bus.o_busy, 0);
        bus.i_enable = 1'b1;
        expect_symbol(181, 0, 0, 2);
        goto(190);
        chk("t6_ovr_none", bus.o_overrun, 0);

        goto(200);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
